// File: rtl/updown_ctrl_pkg.sv
// Shared types and default sizes for the up/down sweep controller.
package updown_ctrl_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int SW_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

endpackage

// File: rtl/updown_load_counter.sv
// Loadable up/down counter; direction is chosen by the caller every cycle.
// Load wins over enable; no wrap protection, the controller keeps it in range.
module updown_load_counter
    import updown_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep controller: runs n triangular lo->hi->lo sweeps on a loadable counter.
// All outputs registered; count is valid the cycle after the start edge.
module updown_sweep_ctrl
    import updown_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SW_W  = SW_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [SW_W-1:0]  n_sweeps,
    output logic [WIDTH-1:0] count,
    output logic             dir_up,
    output logic             busy,
    output logic             done,
    output logic             abort,
    output logic             err,
    output logic [SW_W-1:0]  sweeps_done
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] UP   = ST_UP;
    localparam logic [1:0] DOWN = ST_DOWN;

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] lo_l, hi_l;
    logic [SW_W-1:0]  n_l;
    logic [SW_W-1:0]  sw_nxt;
    logic [WIDTH-1:0] cnt_inc, cnt_dec;
    logic [SW_W-1:0]  sw_inc;
    logic             load, en, up, latch;
    logic             done_nxt, abort_nxt, err_nxt;

    assign cnt_inc = count + 1'b1;
    assign cnt_dec = count - 1'b1;
    assign sw_inc  = sweeps_done + 1'b1;

    updown_load_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (lo),
        .en       (en),
        .up       (up),
        .count    (count)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        en        = 1'b0;
        up        = 1'b0;
        latch     = 1'b0;
        sw_nxt    = sweeps_done;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (lo < hi && n_sweeps != '0) begin
                        load      = 1'b1;
                        latch     = 1'b1;
                        sw_nxt    = '0;
                        state_nxt = UP;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            UP: begin
                if (stop) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (!hold) begin
                    en = 1'b1;
                    up = 1'b1;
                    if (cnt_inc == hi_l) state_nxt = DOWN;
                end
            end
            DOWN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end else if (!hold) begin
                    en = 1'b1;
                    // Reaching lo closes a sweep; the last one ends the run.
                    if (cnt_dec == lo_l) begin
                        sw_nxt = sw_inc;
                        if (sw_inc == n_l) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = UP;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lo_l        <= '0;
            hi_l        <= '0;
            n_l         <= '0;
            sweeps_done <= '0;
            done        <= 1'b0;
            abort       <= 1'b0;
            err         <= 1'b0;
            dir_up      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            sweeps_done <= sw_nxt;
            done        <= done_nxt;
            abort       <= abort_nxt;
            err         <= err_nxt;
            dir_up      <= (state_nxt == UP);
            busy        <= (state_nxt != IDLE);
            if (latch) begin
                lo_l <= lo;
                hi_l <= hi;
                n_l  <= n_sweeps;
            end
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: vector table, corner sequences, random run vs model.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, stop, hold;
    logic [3:0] lo, hi;
    logic [7:0] n_sweeps;
    logic [3:0] count;
    logic       dir_up, busy, done, abort, err;
    logic [7:0] sweeps_done;

    int checks   = 0;
    int failures = 0;

    updown_sweep_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
        .lo          (lo),
        .hi          (hi),
        .n_sweeps    (n_sweeps),
        .count       (count),
        .dir_up      (dir_up),
        .busy        (busy),
        .done        (done),
        .abort       (abort),
        .err         (err),
        .sweeps_done (sweeps_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       start, stop, hold;
        logic [3:0] lo, hi;
        logic [7:0] n;
        logic [3:0] e_count;
        logic       e_dir, e_busy, e_done, e_abort, e_err;
        logic [7:0] e_sw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic sp, logic hd, logic [3:0] l, logic [3:0] h,
                                logic [7:0] n, logic [3:0] c, logic d, logic b, logic dn,
                                logic ab, logic er, logic [7:0] sw);
        vec_t v;
        v.start = st; v.stop = sp; v.hold = hd; v.lo = l; v.hi = h; v.n = n;
        v.e_count = c; v.e_dir = d; v.e_busy = b; v.e_done = dn; v.e_abort = ab;
        v.e_err = er; v.e_sw = sw;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] outs();
        return {count, dir_up, busy, done, abort, err, sweeps_done};
    endfunction

    // Reference model: a run is described only by how many steps it has taken.
    int  m_lo, m_hi, m_n, m_p;
    bit  m_active, m_ran, m_done, m_abort, m_err;

    task automatic model_reset();
        m_lo = 0; m_hi = 0; m_n = 0; m_p = 0;
        m_active = 0; m_ran = 0; m_done = 0; m_abort = 0; m_err = 0;
    endtask

    task automatic model_step(logic st, logic sp, logic hd, int l, int h, int n);
        m_done = 0; m_abort = 0; m_err = 0;
        if (!m_active) begin
            if (st) begin
                if (l < h && n != 0) begin
                    m_lo = l; m_hi = h; m_n = n; m_p = 0;
                    m_active = 1; m_ran = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (sp) begin
            m_active = 0;
            m_abort  = 1;
        end else if (!hd) begin
            m_p++;
            if (m_p == m_n * 2 * (m_hi - m_lo)) begin
                m_active = 0;
                m_done   = 1;
            end
        end
    endtask

    function automatic logic [16:0] model_outs();
        int per, ph, c, sw;
        bit d;
        c = 0; sw = 0; d = 0;
        if (m_ran) begin
            per = 2 * (m_hi - m_lo);
            ph  = m_p % per;
            c   = (ph <= m_hi - m_lo) ? m_lo + ph : m_lo + per - ph;
            sw  = m_p / per;
            d   = m_active && (ph < m_hi - m_lo);
        end
        return {c[3:0], d, m_active, m_done, m_abort, m_err, sw[7:0]};
    endfunction

    initial begin
        reset = 1'b1; start = 0; stop = 0; hold = 0; lo = 0; hi = 0; n_sweeps = 0;
        #12;
        chk("reset_outs", {15'd0, outs()}, 32'd0);
        tick();
        reset = 1'b0;

        // start, stop, hold, lo, hi, n -> count, dir, busy, done, abort, err, sweeps_done
        vecs.push_back(mk(1,0,0, 2,5,1, 2,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 3,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 5,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 3,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 2,0,0,1,0,0,1));
        vecs.push_back(mk(0,0,1, 0,0,0, 2,0,0,0,0,0,1));
        vecs.push_back(mk(1,0,0, 5,5,1, 2,0,0,0,0,1,1));
        vecs.push_back(mk(0,0,0, 5,5,1, 2,0,0,0,0,0,1));
        vecs.push_back(mk(1,0,0, 1,4,0, 2,0,0,0,0,1,1));
        vecs.push_back(mk(1,0,0, 2,5,1, 2,1,1,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,1,1, 3,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,1, 0,0,0, 4,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,1, 0,0,0, 4,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,1, 0,0,0, 4,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 5,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 3,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 2,0,0,1,0,0,1));
        vecs.push_back(mk(1,0,0, 2,5,3, 2,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 3,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 5,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 3,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 2,1,1,0,0,0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 3,1,1,0,0,0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 4,1,1,0,0,0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 5,0,1,0,0,0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 4,0,1,0,0,0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 3,0,1,0,0,0,1));
        vecs.push_back(mk(0,1,1, 0,0,0, 3,0,0,0,1,0,1));
        vecs.push_back(mk(0,1,0, 0,0,0, 3,0,0,0,0,0,1));
        vecs.push_back(mk(1,1,0, 1,2,1, 1,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 2,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,0,0,1,0,0,1));

        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop; hold = vecs[i].hold;
            lo = vecs[i].lo; hi = vecs[i].hi; n_sweeps = vecs[i].n;
            tick();
            chk($sformatf("vec%0d", i), {15'd0, outs()},
                {15'd0, vecs[i].e_count, vecs[i].e_dir, vecs[i].e_busy, vecs[i].e_done,
                 vecs[i].e_abort, vecs[i].e_err, vecs[i].e_sw});
        end
        start = 0; stop = 0; hold = 0;

        // Full-range run: 0..15..0 twice, no wrap, 60 steps.
        start = 1; lo = 4'd0; hi = 4'd15; n_sweeps = 8'd2;
        tick();
        start = 0;
        chk("full_first", {28'd0, count}, 32'd0);
        for (int s = 1; s <= 60; s++) begin
            int ph, c;
            tick();
            ph = s % 30;
            c  = (ph <= 15) ? ph : 30 - ph;
            chk($sformatf("full_cnt%0d", s), {28'd0, count}, c);
            chk($sformatf("full_sw%0d", s), {24'd0, sweeps_done}, s / 30);
            chk($sformatf("full_done%0d", s), {31'd0, done}, (s == 60) ? 1 : 0);
        end
        tick();
        chk("full_idle", {30'd0, busy, done}, 32'd0);

        // Asynchronous reset in the middle of an UP ramp.
        start = 1; lo = 4'd0; hi = 4'd9; n_sweeps = 8'd1;
        tick();
        start = 0;
        tick(); tick(); tick();
        chk("pre_rst_cnt", {28'd0, count}, 32'd3);
        #3 reset = 1'b1;
        #1;
        chk("async_rst", {15'd0, outs()}, 32'd0);
        #1 reset = 1'b0;
        tick();
        chk("post_rst_idle", {15'd0, outs()}, 32'd0);
        start = 1; lo = 4'd2; hi = 4'd4; n_sweeps = 8'd1;
        tick();
        start = 0;
        chk("rerun0", {28'd0, count}, 32'd2);
        tick(); tick(); tick(); tick();
        chk("rerun_end", {15'd0, outs()}, {15'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1});

        // Random traffic against the step-count model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [16:0] exp_o;
            start = ($urandom % 6) == 0;
            stop  = ($urandom % 50) == 0;
            hold  = ($urandom % 5) == 0;
            lo    = 4'($urandom % 16);
            hi    = (($urandom % 8) == 0) ? lo : 4'($urandom % 16);
            n_sweeps = (($urandom % 10) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            model_step(start, stop, hold, int'(lo), int'(hi), int'(n_sweeps));
            exp_o = model_outs();
            tick();
            chk($sformatf("rand%0d", cyc), {15'd0, outs()}, {15'd0, exp_o});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
